// File: rtl/cram_ld_arbiter_pkg.sv
// Shared types and defaults for the CRAM load front-end arbiter.
package cram_ld_arbiter_pkg;

    localparam int NUM_LD_REQ    = 4;
    localparam int WIDTH_LD_DATA = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } fsm_ldarb;

endpackage

// File: rtl/cram_ld_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module cram_ld_arbiter_rr_pick
    import cram_ld_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_LD_REQ,
    parameter int WIDTH_ID = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [WIDTH_ID-1:0] ptr,
    output logic                found,
    output logic [WIDTH_ID-1:0] idx
);

    function automatic logic [WIDTH_ID-1:0] wrap_add(input logic [WIDTH_ID-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return WIDTH_ID'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[wrap_add(ptr, off)]) begin
                found = 1'b1;
                idx   = wrap_add(ptr, off);
            end
        end
    end

endmodule

// File: rtl/cram_ld_arbiter.sv
// Shares one load front-end among NUM_REQ token streams; ownership runs from
// an Acquirement token to its Release, owners are chosen round-robin, and a
// new owner is only picked once the front-end reports idle.
//
// state     | meaning
// ARB_IDLE  | no owner; pick next Acq, consume malformed tokens
// ARB_GRANT | owner's tokens forwarded combinationally
// ARB_DRAIN | Release forwarded; waiting for front-end busy to drop
module cram_ld_arbiter
    import cram_ld_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_LD_REQ,
    parameter int WIDTH_DATA = WIDTH_LD_DATA,
    parameter int WIDTH_ID   = $clog2(NUM_REQ)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 I_Req_Valid,
    input  logic [NUM_REQ-1:0]                 I_Req_Acq,
    input  logic [NUM_REQ-1:0]                 I_Req_Rls,
    input  logic [NUM_REQ-1:0][WIDTH_DATA-1:0] I_Req_Data,
    output logic [NUM_REQ-1:0]                 O_Req_Stall,
    output logic                               O_Valid,
    output logic                               O_Acq,
    output logic                               O_Rls,
    output logic [WIDTH_DATA-1:0]              O_Data,
    input  logic                               I_Stall,
    input  logic                               I_FE_Busy,
    output logic [NUM_REQ-1:0]                 O_Grant,
    output logic [WIDTH_ID-1:0]                O_Grant_ID,
    output logic                               O_Busy,
    output logic                               O_Err
);

    fsm_ldarb            state, state_nxt;
    logic [WIDTH_ID-1:0] r_ptr, ptr_nxt;
    logic [WIDTH_ID-1:0] r_grant, grant_nxt;
    logic                r_acq_seen, acq_seen_nxt;
    logic                r_err, err_nxt;
    logic [NUM_REQ-1:0]  cand;
    logic [NUM_REQ-1:0]  bad_tok;
    logic                pick_found;
    logic [WIDTH_ID-1:0] pick_idx;
    logic                fwd_accept;

    assign cand    = I_Req_Valid & I_Req_Acq & ~I_Req_Rls;
    assign bad_tok = I_Req_Valid & (~I_Req_Acq | I_Req_Rls);

    cram_ld_arbiter_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH_ID (WIDTH_ID)
    ) u_rr_pick (
        .req   (cand),
        .ptr   (r_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_acq_seen <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            r_ptr      <= ptr_nxt;
            r_grant    <= grant_nxt;
            r_acq_seen <= acq_seen_nxt;
            r_err      <= err_nxt;
        end
    end

    // Next-state, forwarding mux and requester stalls.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = r_ptr;
        grant_nxt    = r_grant;
        acq_seen_nxt = r_acq_seen;
        err_nxt      = r_err;
        fwd_accept   = 1'b0;
        O_Req_Stall  = '1;
        O_Valid      = 1'b0;
        O_Acq        = 1'b0;
        O_Rls        = 1'b0;
        O_Data       = '0;
        case (state)
            ARB_IDLE: begin
                // Malformed tokens are swallowed so they cannot wedge a requester.
                O_Req_Stall = ~bad_tok;
                if (|bad_tok) err_nxt = 1'b1;
                if (pick_found) begin
                    grant_nxt    = pick_idx;
                    acq_seen_nxt = 1'b0;
                    state_nxt    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                O_Valid              = I_Req_Valid[r_grant];
                O_Acq                = I_Req_Acq[r_grant];
                O_Rls                = I_Req_Rls[r_grant];
                O_Data               = I_Req_Data[r_grant];
                O_Req_Stall[r_grant] = I_Stall;
                fwd_accept           = I_Req_Valid[r_grant] & ~I_Stall;
                if (fwd_accept && I_Req_Acq[r_grant]) begin
                    if (r_acq_seen) err_nxt = 1'b1;
                    acq_seen_nxt = 1'b1;
                end
                if (fwd_accept && I_Req_Rls[r_grant]) state_nxt = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (!I_FE_Busy) begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = (r_grant == WIDTH_ID'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Owner reporting; the encoded ID stays valid after returning to idle.
    always_comb begin
        O_Grant = '0;
        if (state != ARB_IDLE) O_Grant[r_grant] = 1'b1;
    end

    assign O_Grant_ID = r_grant;
    assign O_Busy     = (state != ARB_IDLE);
    assign O_Err      = r_err;

endmodule
